// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  // Operation encoding, identical to the RV32M funct3 field.
  typedef enum bit [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } MULDIV_OPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Multiply: radix-2 shift-add, 32 cycles. Divide: restoring, 32 cycles.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a
// single-cycle 33x33 signed multiplier (divide is unaffected).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      fn3,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  output logic [XLEN-1:0] result,
  output logic            valid_o,
  input  logic            ready_i
);

  muldiv_state_t state, state_nxt;

  logic [4:0]        cnt;
  MULDIV_OPS         op_q;
  logic              sa_q, sb_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   result_q;

  // Request decode: signedness, special divide cases, direct-to-DONE paths.
  logic            sa_in, sb_in, is_div, b_zero, ovf, special, fast_hit, direct_done, accept;
  logic [XLEN-1:0] special_res, fast_res, mag_a, mag_b;

  assign sa_in   = (fn3 == MULH) || (fn3 == MULHSU) || (fn3 == DIV) || (fn3 == REM);
  assign sb_in   = (fn3 == MULH) || (fn3 == DIV) || (fn3 == REM);
  assign is_div  = fn3[2];
  assign b_zero  = (b == '0);
  assign ovf     = ((fn3 == DIV) || (fn3 == REM)) && (a == INT_MIN) && (b == '1);
  assign special = is_div && (b_zero || ovf);
  assign accept  = (state == IDLE) && valid_i && !kill_i;

  // Division by zero dominates; fn3[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_res = b_zero ? (fn3[1] ? a : DIV_BY_ZERO_Q)
                              : (fn3[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  assign fa       = {sa_in & a[XLEN-1], a};
  assign fb       = {sb_in & b[XLEN-1], b};
  assign fprod    = fa * fb;
  assign fast_hit = !is_div;
  assign fast_res = (fn3 == MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign direct_done = special || fast_hit;

  muldiv_signfix #(.W(XLEN)) u_mag_a (.din(a), .neg(sa_in & a[XLEN-1]), .dout(mag_a));
  muldiv_signfix #(.W(XLEN)) u_mag_b (.din(b), .neg(sb_in & b[XLEN-1]), .dout(mag_b));

  // One iteration step for each algorithm.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // Shift-add: add multiplicand into the upper half when the LSB is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  // Restoring divide: shift {rem,quot} left, trial-subtract divisor, keep on no borrow.
  always_comb begin
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (div_diff[XLEN])
      div_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.din(mul_nxt), .neg(sa_q ^ sb_q), .dout(prod_fix));
  muldiv_signfix #(.W(XLEN)) u_fix_quo (.din(div_nxt[XLEN-1:0]), .neg(sa_q ^ sb_q), .dout(quo_fix));
  muldiv_signfix #(.W(XLEN)) u_fix_rem (.din(div_nxt[2*XLEN-1:XLEN]), .neg(sa_q), .dout(rem_fix));

  // Pick the sign-corrected half/field for the captured op on the final step.
  always_comb begin
    final_res = '0;
    case (op_q)
      MUL:                  final_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:            final_res = quo_fix;
      REM, REMU:            final_res = rem_fix;
      default:              final_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; kill overrides everything.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nxt = direct_done ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == 5'd0) state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill_i) state_nxt = IDLE;
  end

  // Datapath: capture on accept, iterate while busy, drop result on kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      result_q <= '0;
    end else if (kill_i) begin
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q <= MULDIV_OPS'(fn3);
      sa_q <= sa_in & a[XLEN-1];
      sb_q <= sb_in & b[XLEN-1];
      if (special) begin
        result_q <= special_res;
        cnt      <= '0;
      end else if (fast_hit) begin
        result_q <= fast_res;
        cnt      <= '0;
      end else begin
        cnt   <= 5'd31;
        acc   <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        mcand <= is_div ? mag_b : mag_a;
      end
    end else if (state == BUSY) begin
      acc <= op_q[2] ? div_nxt : mul_nxt;
      if (cnt == 5'd0) result_q <= final_res;
      else             cnt      <= cnt - 5'd1;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed, scoreboard-checked bench for muldiv_iter.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [2:0]  fn3;
  logic        valid_i, ready_o, kill_i, valid_o, ready_i;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .fn3(fn3),
    .valid_i(valid_i), .ready_o(ready_o), .kill_i(kill_i),
    .result(result), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its result, check it against the scoreboard,
  // optionally hold off ready_i for `hold` cycles, then hand the result off.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] exp, input int lat,
                        input int hold);
    int n;
    logic [31:0] e;
    int el;
    @(negedge clk);
    n = 0;
    while (!ready_o && n < 60) begin @(negedge clk); n++; end
    a = ia; b = ib; fn3 = f; valid_i = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      valid_i = 1'b0;
      n++;
    end while (!valid_o && n < 60);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!valid_o) begin
      chk({tag, "_timeout"}, 32'(valid_o), 32'd1);
    end else begin
      chk({tag, "_res"}, result, e);
      chk({tag, "_lat"}, 32'(n), 32'(el));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_vld"}, 32'(valid_o), 32'd1);
        chk({tag, "_hold_res"}, result, e);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      chk({tag, "_post_vld"}, 32'(valid_o), 32'd0);
      chk({tag, "_post_rdy"}, 32'(ready_o), 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; a = '0; b = '0; fn3 = '0;
    valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(ready_o), 32'd1);
    chk("rst_vld", 32'(valid_o), 32'd0);
    chk("rst_res", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("mul_zero",    3'd0, 32'd0,          32'h1234_5678, 32'd0,         MUL_LAT, 0);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);
    run_op("divu_z",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("remu_z",      3'd7, 32'd5,          32'd0,         32'd5,         1, 0);
    run_op("div_z",       3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem_z",       3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1, 0);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 10);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14,        33, 0);
    run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         32'd2,         33, 0);
    run_op("divu_ovfops", 3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, 0);
    run_op("div_min_2",   3'd4, 32'h8000_0000,  32'd2,         32'hC000_0000, 33, 0);

    // Kill a DIVU 15 cycles after accept; no result may appear afterwards.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; fn3 = 3'd5; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (14) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_rdy", 32'(ready_o), 32'd1);
    chk("kill_vld", 32'(valid_o), 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("kill_no_vld", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a busy divide.
    a = 32'd1000; b = 32'd3; fn3 = 3'd5; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'(ready_o), 32'd1);
    chk("arst_vld", 32'(valid_o), 32'd0);
    chk("arst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_rst", 3'd5, 32'd1000, 32'd3, 32'd333, 33, 0);
    run_op("mul_after_rst",  3'd0, 32'd123,  32'd456, 32'd56088, MUL_LAT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
